// File: rtl/dram_lsu_port.sv
// Load/store requester for a byte-enabled single-port data RAM with 1-cycle read latency.
// One transaction outstanding; misaligned, out-of-window and illegal-size accesses return an error without touching the RAM.
module dram_lsu_port #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wr_data,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_byte_en,
  input  logic [31:0]           ram_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_e;

  state_e                state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            lane_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [31:0]           ram_wr_data_q;
  logic                  ram_wr_en_q;
  logic [3:0]            ram_wr_byte_en_q;

  logic        req_err_d;
  logic [3:0]  byte_en_d;
  logic [31:0] wr_data_d;
  logic [31:0] lane_data;
  logic [31:0] load_data_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_err_d = 1'b0;
    byte_en_d = 4'b0000;
    wr_data_d = req_wdata;
    case (req_size)
      2'd0: begin
        byte_en_d = 4'b0001 << req_addr[1:0];
        wr_data_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_err_d = req_addr[0];
        byte_en_d = 4'b0011 << req_addr[1:0];
        wr_data_d = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        req_err_d = (req_addr[1:0] != 2'b00);
        byte_en_d = 4'b1111;
      end
      default: req_err_d = 1'b1;
    endcase
    // BASE_ADDR is window-aligned, so the window test reduces to matching the upper bits.
    if (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) req_err_d = 1'b1;
  end

  always_comb begin
    lane_data   = ram_rd_data >> {lane_q, 3'b000};
    load_data_d = lane_data;
    case (size_q)
      2'd0:    load_data_d = uns_q ? {24'b0, lane_data[7:0]}
                                   : {{24{lane_data[7]}}, lane_data[7:0]};
      2'd1:    load_data_d = uns_q ? {16'b0, lane_data[15:0]}
                                   : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_data_d = lane_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      size_q           <= 2'd0;
      uns_q            <= 1'b0;
      lane_q           <= 2'd0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'h0;
      rsp_err_q        <= 1'b0;
      ram_addr_q       <= '0;
      ram_wr_data_q    <= 32'h0;
      ram_wr_en_q      <= 1'b0;
      ram_wr_byte_en_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q   <= req_we;
          size_q <= req_size;
          uns_q  <= req_unsigned;
          lane_q <= req_addr[1:0];
          if (req_err_d) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'h0;
            state_q     <= RESP;
          end else begin
            ram_addr_q  <= req_addr[ADDR_WIDTH+1:2];
            ram_wr_en_q <= req_we;
            if (req_we) begin
              ram_wr_byte_en_q <= byte_en_d;
              ram_wr_data_q    <= wr_data_d;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          ram_wr_en_q      <= 1'b0;
          ram_wr_byte_en_q <= 4'b0000;
          if (we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            state_q <= RDATA;
          end
        end
        RDATA: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_data_d;
          rsp_err_q   <= 1'b0;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wr_data    = ram_wr_data_q;
  assign ram_wr_en      = ram_wr_en_q;
  assign ram_wr_byte_en = ram_wr_byte_en_q;

endmodule

// File: tb/tb_dram_lsu_port.sv
// Bench for dram_lsu_port: behavioural RAM, byte-array reference model, directed and randomized transactions.
module tb_dram_lsu_port;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wr_data, ram_rd_data;
  logic          ram_wr_en;
  logic [3:0]    ram_wr_byte_en;

  int tests = 0;
  int fails = 0;

  dram_lsu_port #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, 1-cycle read latency.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int j = 0; j < 4; j++)
        if (ram_wr_byte_en[j]) ram[ram_addr][8*j +: 8] <= ram_wr_data[8*j +: 8];
    ram_rd_data <= ram[ram_addr];
  end

  // Reference model: flat byte memory of the whole window.
  logic [7:0] ref_mem [0:(4<<AW)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd, input int bp);
    int          nbytes, lat, k, wr_cnt;
    bit          exp_err;
    logic [3:0]  exp_be, cap_be;
    logic [31:0] exp_wd, exp_rd, cap_wd, mask;
    logic [AW-1:0] cap_addr;

    nbytes  = 1 << sz;
    exp_err = (sz == 2'd3) || (a >= (32'd4 << AW)) || ((a % nbytes) != 0);
    exp_be  = 4'b0000;
    exp_rd  = 32'h0;
    exp_wd  = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
    if (!exp_err) begin
      for (int i = 0; i < nbytes; i++) exp_be[(a % 4) + i] = 1'b1;
      if (!we) begin
        for (int i = 0; i < nbytes; i++) exp_rd |= 32'(ref_mem[a + i]) << (8 * i);
        if (nbytes < 4 && !uns && exp_rd[8*nbytes-1]) begin
          mask   = (32'h1 << (8 * nbytes)) - 1;
          exp_rd = exp_rd | ~mask;
        end
      end else begin
        for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
      end
    end
    lat = exp_err ? 1 : (we ? 2 : 3);

    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    wr_cnt = 0; cap_be = '0; cap_wd = '0; cap_addr = '0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ram_wr_en) begin
        wr_cnt++;
        cap_be = ram_wr_byte_en; cap_wd = ram_wr_data; cap_addr = ram_addr;
      end
      if (rsp_valid) break;
    end
    check("latency", k, lat);
    check("wr_pulses", wr_cnt, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) begin
      check("wr_byte_en", {28'b0, cap_be}, {28'b0, exp_be});
      check("wr_data", cap_wd, exp_wd);
      check("wr_addr", {18'b0, cap_addr}, a >> 2);
    end
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);

    repeat (bp) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
      check("hold_ready", {31'b0, req_ready}, 32'd0);
      check("hold_wr_en", {31'b0, ram_wr_en}, 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("post_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_err", {31'b0, rsp_err}, 32'd0);
    check("post_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, keep;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;

    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_ram_addr", {18'b0, ram_addr}, 32'h0);
    check("rst_ram_wr_data", ram_wr_data, 32'h0);
    check("rst_ram_wr_en", {31'b0, ram_wr_en}, 32'd0);
    check("rst_ram_be", {28'b0, ram_wr_byte_en}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5, 0);
    do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0);
    do_req(1'b1, 32'h22, 2'd1, 1'b0, 32'h00008001, 0);
    do_req(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h22, 2'd1, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h06, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h05, 2'd1, 1'b0, 32'h1234, 0);
    do_req(1'b1, 32'h08, 2'd3, 1'b0, 32'h1234, 0);
    do_req(1'b1, 32'h10000, 2'd2, 1'b0, 32'h1234, 0);
    do_req(1'b0, 32'hFFFC, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5);

    // Reset during the ACCESS cycle of a store: strobe dropped, no response, RAM unchanged.
    keep = ram[32'h40 >> 2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_wr_en_before", {31'b0, ram_wr_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_wr_en", {31'b0, ram_wr_en}, 32'd0);
    check("abort_be", {28'b0, ram_wr_byte_en}, 32'h0);
    check("abort_wr_data", ram_wr_data, 32'h0);
    check("abort_ram_addr", {18'b0, ram_addr}, 32'h0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    check("abort_ram_kept", ram[32'h40 >> 2], keep);

    // Randomized traffic in a small region for frequent read-after-write hits.
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = 32'h10000 + $urandom_range(0, 32'hFFFF);
      do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
